// File: rtl/mem_req_router.sv
// mem_req_router: routes a single-outstanding CPU memory request to one of
// N_SLV downstream ports, decoded from an address field. Unmapped accesses
// and slaves that never answer get an error response instead, so every
// accepted request ends in exactly one cpu_rvalid_o pulse.
// Optional request/error counters are built when MEM_REQ_ROUTER_STATS_EN
// is defined.
module mem_req_router #(
  parameter int                          AW          = 32,
  parameter int                          DW          = 32,
  parameter int                          N_SLV       = 2,
  parameter int                          SEL_MSB     = 31,
  parameter int                          SEL_BITS    = 4,
  parameter logic [N_SLV*SEL_BITS-1:0]   SLV_SEL     = {4'h4, 4'h0},
  parameter bit                          DEFAULT_EN  = 1'b1,
  parameter int                          DEFAULT_IDX = 0,
  parameter int                          TIMEOUT     = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AW-1:0]       cpu_addr_i,
  input  logic [DW-1:0]       cpu_wdata_i,
  input  logic                cpu_we_i,
  input  logic                cpu_cs_i,
  output logic [DW-1:0]       cpu_rdata_o,
  output logic                cpu_rvalid_o,
  output logic                cpu_err_o,
  output logic [N_SLV-1:0]    slv_cs_o,
  output logic                slv_we_o,
  output logic [AW-1:0]       slv_addr_o,
  output logic [DW-1:0]       slv_wdata_o,
  input  logic [N_SLV*DW-1:0] slv_rdata_i,
  input  logic [N_SLV-1:0]    slv_rvalid_i,
  output logic                busy_o,
  output logic [15:0]         req_cnt_o,
  output logic [15:0]         err_cnt_o
);

  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              armed_q;
  logic              err_q;
  logic [SW-1:0]     sel_q;
  logic [TW-1:0]     timer_q;

  logic [SEL_BITS-1:0] field;
  logic [N_SLV-1:0]    hit;
  logic [SW-1:0]       dec_sel;
  logic                dec_ok;
  logic [N_SLV-1:0]    dec_onehot;
  logic                sel_rvalid;
  logic [DW-1:0]       sel_rdata;
  logic                accept, issue_done, issue_tmo;

  assign field = cpu_addr_i[SEL_MSB -: SEL_BITS];

  // one comparator per downstream port
  for (genvar k = 0; k < N_SLV; k++) begin : g_hit
    assign hit[k] = (field == SLV_SEL[k*SEL_BITS +: SEL_BITS]);
  end

  // priority pick: walking down means the lowest matching port wins
  always_comb begin
    dec_sel    = SW'(DEFAULT_IDX);
    dec_ok     = DEFAULT_EN;
    dec_onehot = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (hit[k]) begin
        dec_sel = SW'(k);
        dec_ok  = 1'b1;
      end
    end
    dec_onehot[dec_sel] = 1'b1;
  end

  // only the port latched at accept can complete the transaction
  assign sel_rvalid = slv_rvalid_i[sel_q];
  assign sel_rdata  = slv_rdata_i[sel_q*DW +: DW];

  // next-state and transaction events
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue_done = 1'b0;
    issue_tmo  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_cs_i && armed_q) begin
          accept  = 1'b1;
          state_d = dec_ok ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        // a completion in the final timer cycle beats the abort
        if (sel_rvalid) begin
          issue_done = 1'b1;
          state_d    = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          issue_tmo = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, arming guard, request/response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      err_q       <= 1'b0;
      sel_q       <= '0;
      timer_q     <= '0;
      cpu_rdata_o <= '0;
      slv_cs_o    <= '0;
      slv_we_o    <= 1'b0;
      slv_addr_o  <= '0;
      slv_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      // cs must be seen low once between requests, so a cs held through
      // RESP cannot start a second transaction
      if (accept)         armed_q <= 1'b0;
      else if (!cpu_cs_i) armed_q <= 1'b1;

      if (accept) begin
        slv_addr_o  <= cpu_addr_i;
        slv_wdata_o <= cpu_wdata_i;
        slv_we_o    <= cpu_we_i;
        sel_q       <= dec_sel;
        timer_q     <= '0;
        if (dec_ok) begin
          slv_cs_o <= dec_onehot;
        end else begin
          err_q       <= 1'b1;
          cpu_rdata_o <= '0;
        end
      end

      if (state_q == ISSUE) timer_q <= timer_q + TW'(1);

      if (issue_done) begin
        cpu_rdata_o <= sel_rdata;
        err_q       <= 1'b0;
        slv_cs_o    <= '0;
      end

      if (issue_tmo) begin
        cpu_rdata_o <= '0;
        err_q       <= 1'b1;
        slv_cs_o    <= '0;
      end
    end
  end

  assign cpu_rvalid_o = (state_q == RESP);
  assign cpu_err_o    = (state_q == RESP) && err_q;
  assign busy_o       = (state_q != IDLE);

`ifdef MEM_REQ_ROUTER_STATS_EN
  logic [15:0] req_cnt_q, err_cnt_q;

  // saturating accept / error-response counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (accept && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
      if (cpu_err_o && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign req_cnt_o = req_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign req_cnt_o = 16'd0;
  assign err_cnt_o = 16'd0;
`endif

endmodule

// File: doc/mem_req_router.md
Name: mem_req_router

Overview:
- Parametrised successor to the CPU-side memory split. Routes the single-outstanding CPU memory request (addr/wdata/we/cs -> rdata/rvalid) to one of N_SLV downstream request ports.
- Routing is decoded from a programmable address field.
- Adds unmapped-address error responses, a per-transaction timeout and a request-arming guard, so every CPU request gets exactly one response.
- Sits between the riscv_cache core and the AXI4 / AXI4-Lite master adapters, and any future slave adapters.

Parameters:
AW, 32, address width
DW, 32, data width
N_SLV, 2, number of downstream ports (1..8)
SEL_MSB, 31, MSB of the decode field in the address
SEL_BITS, 4, width of the decode field
SLV_SEL, {4'h4, 4'h0}, N_SLV*SEL_BITS flattened match values; port k uses slice [k*SEL_BITS +: SEL_BITS]
DEFAULT_EN, 1, 1: unmatched addresses go to port DEFAULT_IDX; 0: unmatched addresses return an error
DEFAULT_IDX, 0, default port index
TIMEOUT, 256, cycles in ISSUE before the router aborts (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
cpu_addr_i  in  AW  request address
cpu_wdata_i  in  DW  write data
cpu_we_i  in  1  1 = write
cpu_cs_i  in  1  request valid, held by CPU until response
cpu_rdata_o  out  DW  response data, registered
cpu_rvalid_o  out  1  one-cycle response pulse
cpu_err_o  out  1  qualifies cpu_rvalid_o: unmapped or timeout
slv_cs_o  out  N_SLV  one-hot request to selected port
slv_we_o  out  1  registered we
slv_addr_o  out  AW  registered address
slv_wdata_o  out  DW  registered write data
slv_rdata_i  in  N_SLV*DW  per-port read data, flattened
slv_rvalid_i  in  N_SLV  per-port completion (reads and writes)
busy_o  out  1  state != IDLE
req_cnt_o  out  16  accepted requests (see optional feature)
err_cnt_o  out  16  error responses (see optional feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, armed=1, all outputs 0 (slv_* buses, cpu_rdata_o, counters included).
- States: IDLE, ISSUE, RESP.
- Arming guard:
  - armed is set in any cycle where cpu_cs_i=0 and cleared on accept.
  - The CPU must drop cpu_cs_i for >=1 cycle between transactions; a cs held high through RESP is never re-accepted.
- IDLE: accept when cpu_cs_i & armed. Register addr/wdata/we into slv_*_o.
- Decode on field = cpu_addr_i[SEL_MSB -: SEL_BITS]:
  - Port k matches if field == its SLV_SEL slice; lowest matching index wins.
  - No match and DEFAULT_EN=1: route to DEFAULT_IDX.
  - No match and DEFAULT_EN=0: go directly to RESP with err=1, rdata=0, and no slave strobe.
- On match (or default route): next state ISSUE, slv_cs_o = one-hot(sel) from the cycle after accept.
- ISSUE:
  - slv_cs_o, slv_we_o, slv_addr_o and slv_wdata_o are held stable.
  - On slv_rvalid_i[sel]=1: capture slv_rdata_i[sel] into cpu_rdata_o, err=0, clear slv_cs_o, go to RESP.
  - slv_rvalid_i of non-selected ports is ignored in all states.
- Timeout:
  - A timer counts cycles in ISSUE.
  - If the timer reaches TIMEOUT-1 with no rvalid: clear slv_cs_o, rdata=0, err=1, go to RESP.
  - An rvalid in that same cycle wins over the timeout (normal response).
  - A late rvalid after abort is ignored.
- RESP: cpu_rvalid_o=1 and cpu_err_o=err for exactly one cycle, then IDLE.
- Latency: accept at cycle 0, slv_cs_o at cycle 1.
  - Slave rvalid at cycle t gives cpu_rvalid_o at t+1.
  - Unmapped request gives cpu_rvalid_o at cycle 1.
- cpu_rdata_o holds its value until the next response. For writes it carries the slave rdata as returned.
- cpu_cs_i dropping mid-ISSUE does not abort; the transaction completes and the response is still pulsed.
- rst_i mid-transaction returns to IDLE with all strobes low in the next cycle; slaves must tolerate an abandoned request.
- N_SLV=1: decode is still evaluated, so an unmapped access errors when DEFAULT_EN=0.

Optional Feature:
- Macro: MEM_REQ_ROUTER_STATS_EN.
- Defined:
  - req_cnt_o increments on each accept.
  - err_cnt_o increments on each RESP with err=1.
  - Both saturate at 16'hFFFF and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Default params, read addr 0x4000_0010, port1 rvalid 3 cycles after slv_cs_o with rdata 0xCAFE_F00D -> slv_cs_o=2'b10, cpu_rvalid_o one pulse with rdata 0xCAFE_F00D, err=0.
- Write addr 0x0000_0100 wdata 0x1234_5678 -> slv_cs_o=2'b01, slv_we_o=1, slv_wdata_o=0x1234_5678 stable until port0 rvalid; one cpu_rvalid_o pulse.
- DEFAULT_EN=0, read 0x8000_0000 -> cpu_rvalid_o at cycle 1 with err=1, rdata=0, slv_cs_o never asserted, err_cnt_o=1 with STATS_EN.
- TIMEOUT=8, port0 never responds -> slv_cs_o drops after 8 ISSUE cycles, cpu_rvalid_o with err=1; a later port0 rvalid produces no response.
- cpu_cs_i held high for 5 cycles after the response -> no second transaction until cs low for 1 cycle, then re-accept; req_cnt_o=2.
- rst_i asserted during ISSUE -> next cycle busy_o=0, slv_cs_o=0, cpu_rvalid_o=0, counters=0.
